// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq
//   Instruction fetch sequencer for the single-cycle LEGv8 core. Owns the
//   program counter, drives the single-port instruction ROM (1-cycle read
//   latency) and hands instructions to decode over a valid/ready handshake
//   through a 2-entry buffer. Handles branch redirects, decode back-pressure,
//   HLT-terminated programs and out-of-range fetch faults.
//
// Ports
//   clock_i        system clock, rising edge
//   reset_i        asynchronous active-high reset
//   start_i        one-cycle pulse, leaves IDLE and starts fetching at start_pc_i
//   start_pc_i     initial word address, sampled when start_i is accepted
//   rom_en_o       ROM read strobe
//   rom_addr_o     ROM word address (0 when no read is issued)
//   rom_data_i     ROM read data, valid the cycle after rom_en_o
//   br_valid_i     redirect request from execute
//   br_target_i    redirect word address
//   out_valid_o    instruction available to decode
//   out_ready_i    decode accepts the instruction
//   out_instr_o    instruction word (0 while out_valid_o is low)
//   out_pc_o       word address of out_instr_o (0 while out_valid_o is low)
//   halted_o       HLT delivered, fetch stopped
//   fault_o        out-of-range fetch attempted, fetch stopped
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start_i, br_valid_i ignored
// S_RUN   | issuing reads, buffering returns, delivering to decode
// S_HALT  | HLT popped by decode; only reset leaves
// S_FAULT | pc left the ROM and the buffer drained; only reset leaves

module instr_fetch_seq #(
  parameter int unsigned ROM_DEPTH = 32,
  parameter int unsigned PC_W      = 64,
  parameter logic [31:0] HALT_WORD = 32'hD4400000
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [PC_W-1:0] start_pc_i,
  output logic            rom_en_o,
  output logic [PC_W-1:0] rom_addr_o,
  input  logic [31:0]     rom_data_i,
  input  logic            br_valid_i,
  input  logic [PC_W-1:0] br_target_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_instr_o,
  output logic [PC_W-1:0] out_pc_o,
  output logic            halted_o,
  output logic            fault_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(ROM_DEPTH);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            halt_seen_q, halt_seen_d;
  logic [1:0]      count_q, count_d;
  logic [31:0]     instr0_q, instr0_d, instr1_q, instr1_d;
  logic [PC_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;

  logic       run;
  logic       pop;
  logic       push;
  logic       in_range;
  logic       issue;
  logic [1:0] occ;

  // Occupancy seen by the issue rule already excludes an entry leaving this
  // cycle; without that the pipe would only sustain one word every other cycle.
  always_comb begin
    run      = (state_q == S_RUN);
    pop      = run && (count_q != 2'd0) && out_ready_i && !br_valid_i;
    push     = run && inflight_q && !br_valid_i && !halt_seen_q;
    in_range = (pc_q < DEPTH_PC);
    occ      = count_q - {1'b0, pop};
    issue    = run && !br_valid_i && !halt_seen_q && in_range &&
               ((occ + {1'b0, inflight_q}) < 2'd2);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    halt_seen_d   = halt_seen_q;
    count_d       = count_q;
    instr0_d      = instr0_q;
    pc0_d         = pc0_q;
    instr1_d      = instr1_q;
    pc1_d         = pc1_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_RUN;
          pc_d        = start_pc_i;
          halt_seen_d = 1'b0;
          count_d     = 2'd0;
        end
      end

      S_RUN: begin
        if (br_valid_i) begin
          // Flush buffer and squash the in-flight return. An HLT in the
          // flushed buffer was on the wrong path, so fetch resumes.
          pc_d        = br_target_i;
          count_d     = 2'd0;
          halt_seen_d = 1'b0;
        end else begin
          if (pop) begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
          end
          if (push) begin
            if (occ == 2'd0) begin
              instr0_d = rom_data_i;
              pc0_d    = inflight_pc_q;
            end else begin
              instr1_d = rom_data_i;
              pc1_d    = inflight_pc_q;
            end
            if (rom_data_i == HALT_WORD) begin
              halt_seen_d = 1'b1;
            end
          end
          count_d = occ + {1'b0, push};

          if (issue) begin
            pc_d          = pc_q + PC_W'(1);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
          end

          // Nothing is pushed after an HLT, so an HLT at the head is the last word.
          if (pop && (instr0_q == HALT_WORD)) begin
            state_d = S_HALT;
          end else if (!halt_seen_q && !in_range && (count_q == 2'd0) && !inflight_q) begin
            state_d = S_FAULT;
          end
        end
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      halt_seen_q   <= 1'b0;
      count_q       <= 2'd0;
      instr0_q      <= '0;
      pc0_q         <= '0;
      instr1_q      <= '0;
      pc1_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      halt_seen_q   <= halt_seen_d;
      count_q       <= count_d;
      instr0_q      <= instr0_d;
      pc0_q         <= pc0_d;
      instr1_q      <= instr1_d;
      pc1_q         <= pc1_d;
    end
  end

  assign rom_en_o    = issue;
  assign rom_addr_o  = issue ? pc_q : '0;
  assign out_valid_o = (count_q != 2'd0);
  assign out_instr_o = out_valid_o ? instr0_q : '0;
  assign out_pc_o    = out_valid_o ? pc0_q : '0;
  assign halted_o    = (state_q == S_HALT);
  assign fault_o     = (state_q == S_FAULT);

endmodule
